// File: rtl/fp_div_iter.sv
// Iterative restoring single-precision divider (FDIV.S), one quotient bit per cycle.
// Define FP_DIV_FLAGS_EN to add the fflags output {NV,DZ,OF,UF,NX}.
module fp_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  funct7,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        z_s,
  output logic [7:0]  z_e,
  output logic [26:0] z_m
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_NORM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [6:0] FUNCT7_FDIV = 7'b0001100;

  logic [2:0]  state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [24:0] rem;
  logic [27:0] q;
  logic [9:0]  exp_r;
  logic [4:0]  cnt;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic        a_zero;
  logic        b_zero;
  logic        a_inf;
  logic        b_inf;
  logic        a_nan;
  logic        b_nan;
  logic        res_s;

  logic        ge;
  logic [24:0] rem_sub;

  logic [26:0] norm_m;
  logic [9:0]  norm_e;
  logic        norm_of;
  logic        norm_uf;
  logic        rem_nz;

  // Exponent 0 is treated as zero regardless of fraction (subnormals flushed).
  assign ea     = a_r[30:23];
  assign eb     = b_r[30:23];
  assign ma     = {1'b1, a_r[22:0]};
  assign mb     = {1'b1, b_r[22:0]};
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
  assign res_s  = a_r[31] ^ b_r[31];

  assign ge      = (rem >= {1'b0, mb});
  assign rem_sub = ge ? (rem - {1'b0, mb}) : rem;
  assign rem_nz  = (rem != 25'd0);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Quotient lies in [0.5, 2); a clear top bit means one extra left shift.
  always_comb begin
    norm_m = {q[27:2], q[1] | q[0] | rem_nz};
    norm_e = exp_r;
    if (!q[27]) begin
      norm_m = {q[26:1], q[0] | rem_nz};
      norm_e = exp_r - 10'd1;
    end
    norm_of = ($signed(norm_e) >= $signed(10'd255));
    norm_uf = ($signed(norm_e) <= $signed(10'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      rem    <= 25'd0;
      q      <= 28'd0;
      exp_r  <= 10'd0;
      cnt    <= 5'd0;
      z_s    <= 1'b0;
      z_e    <= 8'd0;
      z_m    <= 27'd0;
`ifdef FP_DIV_FLAGS_EN
      fflags <= 5'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (funct7 == FUNCT7_FDIV)) begin
            a_r   <= a;
            b_r   <= b;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            z_s    <= 1'b0;
            z_e    <= 8'hFF;
            z_m    <= 27'h2000000;
`ifdef FP_DIV_FLAGS_EN
            fflags <= 5'b10000;
`endif
            state  <= S_DONE;
          end else if (b_zero) begin
            z_s    <= res_s;
            z_e    <= 8'hFF;
            z_m    <= 27'd0;
`ifdef FP_DIV_FLAGS_EN
            fflags <= 5'b01000;
`endif
            state  <= S_DONE;
          end else if (a_inf) begin
            z_s    <= res_s;
            z_e    <= 8'hFF;
            z_m    <= 27'd0;
`ifdef FP_DIV_FLAGS_EN
            fflags <= 5'b00000;
`endif
            state  <= S_DONE;
          end else if (a_zero || b_inf) begin
            z_s    <= res_s;
            z_e    <= 8'h00;
            z_m    <= 27'd0;
`ifdef FP_DIV_FLAGS_EN
            fflags <= 5'b00000;
`endif
            state  <= S_DONE;
          end else begin
            rem   <= {1'b0, ma};
            q     <= 28'd0;
            exp_r <= {2'b00, ea} - {2'b00, eb} + 10'd127;
            cnt   <= 5'd27;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          q   <= {q[26:0], ge};
          rem <= rem_sub << 1;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          z_s <= res_s;
          if (norm_of) begin
            z_e    <= 8'hFF;
            z_m    <= 27'd0;
`ifdef FP_DIV_FLAGS_EN
            fflags <= 5'b00101;
`endif
          end else if (norm_uf) begin
            z_e    <= 8'h00;
            z_m    <= 27'd0;
`ifdef FP_DIV_FLAGS_EN
            fflags <= 5'b00011;
`endif
          end else begin
            z_e    <= norm_e[7:0];
            z_m    <= norm_m;
`ifdef FP_DIV_FLAGS_EN
            fflags <= {4'b0000, |norm_m[2:0]};
`endif
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed cases, random operands against
// an integer-division reference model, plus handshake / reset corner cases.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  funct7;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        z_s;
  logic [7:0]  z_e;
  logic [26:0] z_m;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  fflags;
`endif

  localparam logic [6:0] FDIV = 7'b0001100;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct7 (funct7),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .z_s    (z_s),
    .z_e    (z_e),
    .z_m    (z_m)
`ifdef FP_DIV_FLAGS_EN
    ,
    .fflags (fflags)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: {flags[4:0], sign, exp[7:0], mant[26:0]} from the IEEE rules
  // with the mantissa quotient taken by plain 64-bit integer division.
  function automatic logic [40:0] refDiv(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e;
    bit          xz, yz, xi, yi, xn, yn;
    logic        s;
    longint      num, den, qq, rr;
    logic [27:0] qb;
    logic [26:0] m;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    s  = x[31] ^ y[31];
    if (xn || yn || (xz && yz) || (xi && yi)) return {5'b10000, 1'b0, 8'hFF, 27'h2000000};
    if (yz) return {5'b01000, s, 8'hFF, 27'd0};
    if (xi) return {5'b00000, s, 8'hFF, 27'd0};
    if (xz || yi) return {5'b00000, s, 8'h00, 27'd0};
    num = longint'({1'b1, x[22:0]}) << 27;
    den = longint'({1'b1, y[22:0]});
    qq  = num / den;
    rr  = num % den;
    qb  = qq[27:0];
    e   = ex - ey + 127;
    if (qb[27]) begin
      m = {qb[27:2], qb[1] | qb[0] | (rr != 0)};
    end else begin
      m = {qb[26:1], qb[0] | (rr != 0)};
      e = e - 1;
    end
    if (e >= 255) return {5'b00101, s, 8'hFF, 27'd0};
    if (e <= 0) return {5'b00011, s, 8'h00, 27'd0};
    return {4'b0000, |m[2:0], s, 8'(e), m};
  endfunction

  function automatic bit isSpecial(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] randOperand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      3: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input string name);
    logic [40:0] expv;
    int          lat;
    bit          seen;
    expv = refDiv(x, y);
    @(negedge clk);
    checkOutput({name, "_idle_done"}, 32'(done), 32'd0);
    checkOutput({name, "_idle_busy"}, 32'(busy), 32'd0);
    start  = 1'b1;
    funct7 = FDIV;
    a      = x;
    b      = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    checkOutput({name, "_busy"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, "_latency"}, 32'(lat), isSpecial(x, y) ? 32'd1 : 32'd30);
      checkOutput({name, "_busy_done"}, 32'(busy), 32'd1);
      checkOutput({name, "_z_s"}, 32'(z_s), 32'(expv[35]));
      checkOutput({name, "_z_e"}, 32'(z_e), 32'(expv[34:27]));
      checkOutput({name, "_z_m"}, 32'(z_m), 32'(expv[26:0]));
`ifdef FP_DIV_FLAGS_EN
      checkOutput({name, "_fflags"}, 32'(fflags), 32'(expv[40:36]));
`endif
    end
  endtask

  initial begin
    logic [40:0] expv;
    int          dones;
    rst    = 1'b1;
    start  = 1'b0;
    funct7 = 7'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_z_s", 32'(z_s), 32'd0);
    checkOutput("rst_z_e", 32'(z_e), 32'd0);
    checkOutput("rst_z_m", 32'(z_m), 32'd0);
`ifdef FP_DIV_FLAGS_EN
    checkOutput("rst_fflags", 32'(fflags), 32'd0);
`endif
    rst = 1'b0;

    applyStimulus(32'h40C00000, 32'h40000000, "six_by_two");
    applyStimulus(32'h3F800000, 32'h40400000, "one_third");
    applyStimulus(32'hBF800000, 32'h00000000, "div_zero");
    applyStimulus(32'h00000000, 32'h00000000, "zero_zero");
    applyStimulus(32'h7F000000, 32'h00800000, "overflow");
    applyStimulus(32'h00800000, 32'h7F000000, "underflow");
    applyStimulus(32'h7F800000, 32'h7F800000, "inf_inf");
    applyStimulus(32'hFF800000, 32'h3F800000, "inf_x");
    applyStimulus(32'h3F800000, 32'hFF800000, "x_inf");
    applyStimulus(32'h7FC00001, 32'h3F800000, "nan_x");
    applyStimulus(32'h00123456, 32'h3F800000, "subnormal_flush");

    for (int i = 0; i < 150; i++) begin
      applyStimulus(randOperand(), randOperand(), "rnd");
    end

    // Wrong funct7 must leave the block idle.
    @(negedge clk);
    start  = 1'b1;
    funct7 = 7'b0000000;
    a      = 32'h40C00000;
    b      = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("bad_funct7_busy", 32'(busy), 32'd0);
    dones = 0;
    repeat (35) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("bad_funct7_dones", 32'(dones), 32'd0);

    // A second start while busy is ignored: exactly one done, first operands win.
    expv = refDiv(32'h40C00000, 32'h40000000);
    start  = 1'b1;
    funct7 = FDIV;
    a      = 32'h40C00000;
    b      = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (45) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("double_start_dones", 32'(dones), 32'd1);
    checkOutput("double_start_z_e", 32'(z_e), 32'(expv[34:27]));
    checkOutput("double_start_z_m", 32'(z_m), 32'(expv[26:0]));

    // Mid-operation reset at T+10 aborts and clears all outputs.
    start = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_z_s", 32'(z_s), 32'd0);
    checkOutput("mid_rst_z_e", 32'(z_e), 32'd0);
    checkOutput("mid_rst_z_m", 32'(z_m), 32'd0);
`ifdef FP_DIV_FLAGS_EN
    checkOutput("mid_rst_fflags", 32'(fflags), 32'd0);
`endif
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("mid_rst_dones", 32'(dones), 32'd0);

    applyStimulus(32'hC1200000, 32'h40A00000, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Iterative single-precision divider for FDIV.S. It unpacks two IEEE-754 operands from the FP register-file read ports and performs restoring mantissa division, one quotient bit per cycle. It delivers sign, biased exponent and a 27-bit guard/round/sticky mantissa in the same format the FP add, sub and mul units hand to the 4:1 result mux and the rounding stage. It replaces the combinational divide path, so the datapath handshakes with it via start/done.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only in IDLE when funct7 == 7'b0001100.
- funct7  in  7  instr[31:25] of the issuing instruction.
- a  in  32  dividend (rs1 value).
- b  in  32  divisor (rs2 value).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; z_* are valid from this cycle onward.
- z_s  out  1  result sign.
- z_e  out  8  biased result exponent.
- z_m  out  27  [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- fflags  out  5  {NV,DZ,OF,UF,NX}; present only with FP_DIV_FLAGS_EN.

## Operation
- States: IDLE, PREP, DIV, NORM, DONE.
- IDLE→PREP on an accepted start; a and b are latched on that edge.
- PREP: unpack the operands. Exponent 0 is flushed to zero (no subnormals). Special-case checks, first match wins:
  - NaN operand, 0/0 or inf/inf → z_s=0, z_e=8'hFF, z_m=27'h2000000, NV.
  - x/0 → inf (z_e=FF, z_m=0), sign = sa^sb, DZ.
  - inf/x → inf.
  - 0/x or x/inf → signed zero.
  - A special case goes directly to DONE.
- PREP→DIV for finite, nonzero operands:
  - rem = {1'b0, ma} (25 bits); exp = ea − eb + 127, 10-bit signed; counter = 27.
- DIV, each cycle: if rem >= mb then q = {q, 1}, rem −= mb; else q = {q, 0}. Then rem <<= 1 and counter decrements. Exactly 28 cycles, then go to NORM.
- NORM:
  - If q[27]: z_m = {q[27:2], q[1] | q[0] | (rem != 0)}.
  - Else: z_m = {q[26:1], q[0] | (rem != 0)} and exp −= 1.
  - If exp >= 255: inf, OF, NX.
  - If exp <= 0: signed zero, UF, NX.
  - NX is set if any of the GRS bits is nonzero.
- DONE: raise done and return to IDLE on the next edge.
- z_s, z_e, z_m and fflags are registered. They hold their value until the next operation's DONE.
- start is ignored while busy.

## Timing
- Reset: state = IDLE; busy, done, z_s, z_e, z_m and fflags are all 0.
- Reset has priority over start. A mid-operation reset aborts the operation; no done is produced.
- With start sampled at edge T:
  - busy is high from T+1 through the DONE cycle.
  - Normal operand: done is high in the cycle after edge T+30.
  - Special case: done is high in the cycle after edge T+1.
- Back-to-back operation: start may be asserted in the cycle after done and is accepted.
- start together with a wrong funct7 is ignored; the block stays in IDLE.

## Configuration
- FP_DIV_FLAGS_EN defined: the fflags port exists and follows the rules above.
- Not defined: the port and all flag logic are absent. Results and latency are identical either way.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → z_s=0, z_e=0x80, z_m=0x6000000, NX=0; done after 30 edges.
- 0x3F800000 / 0x40400000 (1/3) → z_e=0x7D, z_m=0x5555555, NX=1.
- 0xBF800000 / 0x00000000 → z_s=1, z_e=0xFF, z_m=0, DZ=1; done after 1 edge.
- 0x00000000 / 0x00000000 → z_e=0xFF, z_m=0x2000000, NV=1.
- 0x7F000000 / 0x00800000 → inf, OF=1, NX=1. Separately, 0x00800000 / 0x7F000000 → zero, UF=1.
- Second start at T+5 → ignored, only one done. Then rst at T+10 → busy=0 and all outputs 0 at T+11, no done.
